// File: rtl/as6s_fwft_prefetch_sfifo_if.sv
// Handshake bundle for the single-clock FWFT prefetch FIFO.
// The producer/consumer side uses master, the FIFO uses slave.
interface as6s_fwft_prefetch_sfifo_if #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_en;
    logic                  rd_en;
    logic [ADDR_WIDTH:0]   prog_full_assert_cfg;
    logic [ADDR_WIDTH:0]   prog_full_negate_cfg;
    logic [ADDR_WIDTH:0]   prog_empty_assert_cfg;
    logic [ADDR_WIDTH:0]   prog_empty_negate_cfg;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_data_val;
    logic                  empty;
    logic                  full;
    logic                  prog_full;
    logic                  prog_empty;
    logic [ADDR_WIDTH:0]   data_count;
    logic                  ovf_int;
    logic                  udf_int;

    modport master (
        output wr_data, wr_en, rd_en,
               prog_full_assert_cfg, prog_full_negate_cfg,
               prog_empty_assert_cfg, prog_empty_negate_cfg,
        input  rd_data, rd_data_val, empty, full, prog_full, prog_empty,
               data_count, ovf_int, udf_int
    );

    modport slave (
        input  wr_data, wr_en, rd_en,
               prog_full_assert_cfg, prog_full_negate_cfg,
               prog_empty_assert_cfg, prog_empty_negate_cfg,
        output rd_data, rd_data_val, empty, full, prog_full, prog_empty,
               data_count, ovf_int, udf_int
    );
endinterface

// File: rtl/as6s_fwft_prefetch_sfifo.sv
// Single-clock FWFT FIFO: flop storage read through a modelled RAM pipeline,
// with a ring of prefetch slots that hides the read latency at one word per cycle.
module as6s_fwft_prefetch_sfifo #(
    parameter int DATA_WIDTH     = 128,
    parameter int ADDR_WIDTH     = 4,
    parameter int FIFO_DEEP      = 1 << ADDR_WIDTH,
    parameter int RAM_PIPE_STAGE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    as6s_fwft_prefetch_sfifo_if.slave bus
);
    localparam int PRE_REG_NUM = RAM_PIPE_STAGE + 2;
    localparam int SW          = $clog2(PRE_REG_NUM);
    localparam int CW          = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEEP_C = CW'(FIFO_DEEP);
    localparam logic [CW-1:0] PRE_C  = CW'(PRE_REG_NUM);

    logic                  srst;
    logic [CW-1:0]         wptr, rptr, ram_count;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEEP];

    logic [SW-1:0]             in_ptr, out_ptr;
    logic [PRE_REG_NUM-1:0]    slot_valid;
    logic [DATA_WIDTH-1:0]     slot_data [PRE_REG_NUM];
    logic [RAM_PIPE_STAGE-1:0] pipe_val;
    logic [DATA_WIDTH-1:0]     pipe_data [RAM_PIPE_STAGE];
    logic [SW-1:0]             pipe_tag  [RAM_PIPE_STAGE];
    logic [CW-1:0]             inflight_cnt, slot_cnt;

    logic          full, wen, fetch, land, head_val, ren;
    logic [SW-1:0] land_tag;
    logic [CW-1:0] data_count;
    logic          prog_full, prog_empty, ovf_int, udf_int;

    function automatic logic [SW-1:0] slot_next(input logic [SW-1:0] p);
        return (p == SW'(PRE_REG_NUM - 1)) ? '0 : p + SW'(1);
    endfunction

    assign srst      = rst | clear;
    assign ram_count = wptr - rptr;
    assign full      = (ram_count == DEEP_C);
    assign wen       = bus.wr_en & ~full;
    // Slots freed by this cycle's read are not counted free until next cycle.
    assign fetch     = (ram_count != '0) && ((slot_cnt + inflight_cnt) < PRE_C);
    assign land      = pipe_val[RAM_PIPE_STAGE-1];
    assign land_tag  = pipe_tag[RAM_PIPE_STAGE-1];
    assign head_val  = slot_valid[out_ptr];
    assign ren       = bus.rd_en & head_val;
    assign data_count = ram_count + inflight_cnt + slot_cnt;

    // NOTE: data arrays have no reset; every word is qualified by a valid bit or pointer.
    always_ff @(posedge clk) begin
        if (wen && !srst) mem[wptr[ADDR_WIDTH-1:0]] <= bus.wr_data;
        pipe_data[0] <= mem[rptr[ADDR_WIDTH-1:0]];
        pipe_tag[0]  <= in_ptr;
        for (int i = 1; i < RAM_PIPE_STAGE; i++) begin
            pipe_data[i] <= pipe_data[i-1];
            pipe_tag[i]  <= pipe_tag[i-1];
        end
        if (land) slot_data[land_tag] <= pipe_data[RAM_PIPE_STAGE-1];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (srst) begin
            wptr         <= '0;
            rptr         <= '0;
            in_ptr       <= '0;
            out_ptr      <= '0;
            slot_valid   <= '0;
            pipe_val     <= '0;
            inflight_cnt <= '0;
            slot_cnt     <= '0;
        end else begin
            if (wen) wptr <= wptr + CW'(1);
            if (fetch) begin
                rptr   <= rptr + CW'(1);
                in_ptr <= slot_next(in_ptr);
            end
            pipe_val[0] <= fetch;
            for (int i = 1; i < RAM_PIPE_STAGE; i++) pipe_val[i] <= pipe_val[i-1];
            // A landing slot was reserved empty, so it never collides with the head being read.
            if (land) slot_valid[land_tag] <= 1'b1;
            if (ren) begin
                slot_valid[out_ptr] <= 1'b0;
                out_ptr             <= slot_next(out_ptr);
            end
            inflight_cnt <= inflight_cnt + CW'(fetch) - CW'(land);
            slot_cnt     <= slot_cnt + CW'(land) - CW'(ren);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            prog_full  <= 1'b0;
            prog_empty <= 1'b1;
            ovf_int    <= 1'b0;
            udf_int    <= 1'b0;
        end else begin
            if (data_count >= bus.prog_full_assert_cfg)       prog_full <= 1'b1;
            else if (data_count <= bus.prog_full_negate_cfg)  prog_full <= 1'b0;
            if (data_count <= bus.prog_empty_assert_cfg)      prog_empty <= 1'b1;
            else if (data_count >= bus.prog_empty_negate_cfg) prog_empty <= 1'b0;
            ovf_int <= bus.wr_en & full;
            udf_int <= bus.rd_en & ~head_val;
        end
    end

    assign bus.rd_data     = head_val ? slot_data[out_ptr] : '0;
    assign bus.rd_data_val = head_val;
    assign bus.empty       = ~head_val;
    assign bus.full        = full;
    assign bus.prog_full   = prog_full;
    assign bus.prog_empty  = prog_empty;
    assign bus.data_count  = data_count;
    assign bus.ovf_int     = ovf_int;
    assign bus.udf_int     = udf_int;
endmodule

// File: tb/tb_as6s_fwft_prefetch_sfifo.sv
// Directed bench for as6s_fwft_prefetch_sfifo: a vector table for the count/flag walk,
// plus hand-written sequences for reset, fill/drain, latency, streaming and clear.
module tb_as6s_fwft_prefetch_sfifo;
    localparam int DW = 128;
    localparam int AW = 4;
    typedef logic [DW-1:0] word_t;

    typedef struct {
        logic  wr_en;
        logic  rd_en;
        word_t wr_data;
        logic  chk_head;
        word_t exp_head;
        int    exp_count;
        logic  exp_pf;
        logic  exp_pe;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic clear;
    always #5 clk = ~clk;

    as6s_fwft_prefetch_sfifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus (), bus1 (), bus4 ();

    as6s_fwft_prefetch_sfifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_PIPE_STAGE(2))
        dut  (.clk(clk), .rst(rst), .clear(clear), .bus(bus.slave));
    as6s_fwft_prefetch_sfifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_PIPE_STAGE(1))
        dut1 (.clk(clk), .rst(rst), .clear(clear), .bus(bus1.slave));
    as6s_fwft_prefetch_sfifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_PIPE_STAGE(4))
        dut4 (.clk(clk), .rst(rst), .clear(clear), .bus(bus4.slave));

    int n_checks = 0;
    int n_pass   = 0;
    vec_t  vecs[29];
    word_t q[$];

    task automatic check(input string name, input word_t act, input word_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_en = 1'b0;  bus.rd_en = 1'b0;  bus.wr_data = '0;
        bus1.wr_en = 1'b0; bus1.rd_en = 1'b0; bus1.wr_data = '0;
        bus4.wr_en = 1'b0; bus4.rd_en = 1'b0; bus4.wr_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear = 1'b0;
        idle_inputs();
        bus.prog_full_assert_cfg  = 5'd12; bus.prog_full_negate_cfg  = 5'd8;
        bus.prog_empty_assert_cfg = 5'd2;  bus.prog_empty_negate_cfg = 5'd5;
        bus1.prog_full_assert_cfg  = 5'd12; bus1.prog_full_negate_cfg  = 5'd8;
        bus1.prog_empty_assert_cfg = 5'd2;  bus1.prog_empty_negate_cfg = 5'd5;
        bus4.prog_full_assert_cfg  = 5'd12; bus4.prog_full_negate_cfg  = 5'd8;
        bus4.prog_empty_assert_cfg = 5'd2;  bus4.prog_empty_negate_cfg = 5'd5;

        // Count walk 0 -> 14 -> 0: flags reflect the count of the previous edge.
        for (int i = 0; i < 29; i++) begin
            int n;
            n = i + 1;
            vecs[i].wr_en     = (n <= 14);
            vecs[i].rd_en     = (n >= 15 && n <= 28);
            vecs[i].wr_data   = word_t'(n - 1);
            vecs[i].chk_head  = (n >= 15 && n <= 28);
            vecs[i].exp_head  = word_t'(n - 15);
            vecs[i].exp_count = (n <= 14) ? n : 28 - n;
            vecs[i].exp_pf    = (n >= 13 && n <= 20);
            vecs[i].exp_pe    = (n <= 5 || n >= 27);
        end
        if (vecs[28].exp_count != 0) vecs[28].exp_count = 0;

        // Reset with a write pending: nothing is accepted.
        bus.wr_en = 1'b1;
        bus.wr_data = word_t'(32'hDEAD);
        tick();
        check("rst_count_cycle1", word_t'(bus.data_count), word_t'(0));
        tick();
        check("rst_count_cycle2", word_t'(bus.data_count), word_t'(0));
        check("rst_ovf", word_t'(bus.ovf_int), word_t'(0));
        bus.wr_en = 1'b0;
        rst = 1'b0;
        check("rst_rd_data", bus.rd_data, word_t'(0));
        check("rst_rd_data_val", word_t'(bus.rd_data_val), word_t'(0));
        check("rst_empty", word_t'(bus.empty), word_t'(1));
        check("rst_full", word_t'(bus.full), word_t'(0));
        check("rst_prog_full", word_t'(bus.prog_full), word_t'(0));
        check("rst_prog_empty", word_t'(bus.prog_empty), word_t'(1));
        check("rst_udf", word_t'(bus.udf_int), word_t'(0));
        tick();
        check("post_rst_count", word_t'(bus.data_count), word_t'(0));

        // Table-driven hysteresis walk.
        do_reset();
        for (int i = 0; i < 29; i++) begin
            bus.wr_en   = vecs[i].wr_en;
            bus.rd_en   = vecs[i].rd_en;
            bus.wr_data = vecs[i].wr_data;
            if (vecs[i].chk_head) begin
                check($sformatf("hyst_head_val[%0d]", i), word_t'(bus.rd_data_val), word_t'(1));
                check($sformatf("hyst_head_data[%0d]", i), bus.rd_data, vecs[i].exp_head);
            end
            tick();
            check($sformatf("hyst_count[%0d]", i), word_t'(bus.data_count), word_t'(vecs[i].exp_count));
            check($sformatf("hyst_pf[%0d]", i), word_t'(bus.prog_full), word_t'(vecs[i].exp_pf));
            check($sformatf("hyst_pe[%0d]", i), word_t'(bus.prog_empty), word_t'(vecs[i].exp_pe));
        end
        idle_inputs();

        // Fill to 20 (16 in storage + 4 in slots), overflow, drain, underflow.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            bus.wr_en = 1'b1;
            bus.wr_data = word_t'(i);
            tick();
            if (i == 18) check("fill_not_full_at_19", word_t'(bus.full), word_t'(0));
        end
        check("fill_count_20", word_t'(bus.data_count), word_t'(20));
        check("fill_full", word_t'(bus.full), word_t'(1));
        check("fill_head_val", word_t'(bus.rd_data_val), word_t'(1));
        check("fill_head_data", bus.rd_data, word_t'(0));
        bus.wr_data = word_t'(32'hEE);
        tick();
        check("ovf_pulse", word_t'(bus.ovf_int), word_t'(1));
        check("ovf_count_held", word_t'(bus.data_count), word_t'(20));
        bus.wr_en = 1'b0;
        tick();
        check("ovf_clears", word_t'(bus.ovf_int), word_t'(0));
        bus.rd_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check($sformatf("drain_val[%0d]", i), word_t'(bus.rd_data_val), word_t'(1));
            check($sformatf("drain_data[%0d]", i), bus.rd_data, word_t'(i));
            tick();
        end
        check("drain_empty", word_t'(bus.empty), word_t'(1));
        check("drain_count_0", word_t'(bus.data_count), word_t'(0));
        check("drain_no_udf", word_t'(bus.udf_int), word_t'(0));
        tick();
        check("udf_pulse", word_t'(bus.udf_int), word_t'(1));
        bus.rd_en = 1'b0;
        tick();
        check("udf_clears", word_t'(bus.udf_int), word_t'(0));

        // Write-to-valid latency for pipe depths 2, 1 and 4.
        do_reset();
        bus.wr_en = 1'b1;  bus.wr_data = word_t'(8'hA5);
        bus1.wr_en = 1'b1; bus1.wr_data = word_t'(8'hA5);
        bus4.wr_en = 1'b1; bus4.wr_data = word_t'(8'hA5);
        tick();
        idle_inputs();
        for (int t = 0; t <= 5; t++) begin
            check($sformatf("lat2_val[k+%0d]", t), word_t'(bus.rd_data_val), word_t'(t >= 3));
            check($sformatf("lat2_data[k+%0d]", t), bus.rd_data, (t >= 3) ? word_t'(8'hA5) : word_t'(0));
            check($sformatf("lat1_val[k+%0d]", t), word_t'(bus1.rd_data_val), word_t'(t >= 2));
            check($sformatf("lat1_data[k+%0d]", t), bus1.rd_data, (t >= 2) ? word_t'(8'hA5) : word_t'(0));
            check($sformatf("lat4_val[k+%0d]", t), word_t'(bus4.rd_data_val), word_t'(t >= 5));
            check($sformatf("lat4_data[k+%0d]", t), bus4.rd_data, (t >= 5) ? word_t'(8'hA5) : word_t'(0));
            tick();
        end

        // Streaming with 8 preloaded: paired read/write keeps count at 8 and never bubbles.
        do_reset();
        q.delete();
        for (int i = 0; i < 8; i++) begin
            bus.wr_en = 1'b1;
            bus.wr_data = word_t'(32'h100 + i);
            q.push_back(bus.wr_data);
            tick();
        end
        bus.wr_en = 1'b0;
        repeat (6) tick();
        for (int c = 0; c < 100; c++) begin
            logic go;
            go = 1'($urandom_range(0, 1));
            bus.wr_en = go;
            bus.rd_en = go;
            bus.wr_data = {$urandom, $urandom, $urandom, $urandom};
            check($sformatf("stream_val[%0d]", c), word_t'(bus.rd_data_val), word_t'(1));
            check($sformatf("stream_data[%0d]", c), bus.rd_data, q[0]);
            if (go) begin
                void'(q.pop_front());
                q.push_back(bus.wr_data);
            end
            tick();
            check($sformatf("stream_count[%0d]", c), word_t'(bus.data_count), word_t'(8));
        end
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("stream_tail[%0d]", i), bus.rd_data, q[0]);
            void'(q.pop_front());
            tick();
        end
        bus.rd_en = 1'b0;
        check("stream_end_empty", word_t'(bus.empty), word_t'(1));

        // Clear with 2 words in slots and 3 still on their way.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.wr_en = 1'b1;
            bus.wr_data = word_t'(32'h50 + i);
            tick();
        end
        bus.wr_en = 1'b0;
        check("preclear_count", word_t'(bus.data_count), word_t'(5));
        check("preclear_head", bus.rd_data, word_t'(32'h50));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_count", word_t'(bus.data_count), word_t'(0));
        check("clear_empty", word_t'(bus.empty), word_t'(1));
        for (int i = 0; i < 6; i++) begin
            check($sformatf("clear_no_stale[%0d]", i), word_t'(bus.rd_data_val), word_t'(0));
            tick();
        end
        bus.wr_en = 1'b1;
        bus.wr_data = word_t'(8'h3C);
        tick();
        bus.wr_en = 1'b0;
        tick();
        tick();
        check("after_clear_val_k2", word_t'(bus.rd_data_val), word_t'(0));
        tick();
        check("after_clear_val_k3", word_t'(bus.rd_data_val), word_t'(1));
        check("after_clear_data", bus.rd_data, word_t'(8'h3C));
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        check("after_clear_empty", word_t'(bus.empty), word_t'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
